// File: rtl/sram_rr_arbiter_if.sv
// Client and SRAM-side signal bundle for the round-robin SRAM arbiter.
// The arbiter takes the slave view; clients and the SRAM controller take the master view.
interface sram_rr_arbiter_if #(
    parameter int NW = 2,
    parameter int NR = 2,
    parameter int AW = 18,
    parameter int DW = 32,
    parameter int MW = DW / 8
);
    logic [NW-1:0]           w_valid;
    logic [NW-1:0]           w_ready;
    logic [NW*(MW+AW+DW)-1:0] w_din;
    logic [NR-1:0]           r_addr_valid;
    logic [NR-1:0]           r_addr_ready;
    logic [NR*AW-1:0]        r_addr;
    logic [NR-1:0]           r_data_valid;
    logic [NR-1:0]           r_data_ready;
    logic [NR*DW-1:0]        r_data;
    logic                    sram_addr_valid;
    logic                    sram_ready;
    logic [AW-1:0]           sram_addr;
    logic [DW-1:0]           sram_data_in;
    logic [MW-1:0]           sram_write_mask;
    logic [DW-1:0]           sram_data_out;
    logic                    sram_data_out_valid;
    logic                    protocol_err;

    modport slave (
        input  w_valid, w_din, r_addr_valid, r_addr, r_data_ready,
        input  sram_ready, sram_data_out, sram_data_out_valid,
        output w_ready, r_addr_ready, r_data_valid, r_data,
        output sram_addr_valid, sram_addr, sram_data_in,
        output sram_write_mask, protocol_err
    );

    modport master (
        output w_valid, w_din, r_addr_valid, r_addr, r_data_ready,
        output sram_ready, sram_data_out, sram_data_out_valid,
        input  w_ready, r_addr_ready, r_data_valid, r_data,
        input  sram_addr_valid, sram_addr, sram_data_in,
        input  sram_write_mask, protocol_err
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM command port among write and read clients,
// with in-order read returns steered back to per-port buffers via a tag FIFO.
module sram_rr_arbiter #(
    parameter int NW         = 2,
    parameter int NR         = 2,
    parameter int AW         = 18,
    parameter int DW         = 32,
    parameter int MW         = DW / 8,
    parameter int TAG_DEPTH  = 8,
    parameter int RBUF_DEPTH = 4
) (
    input  logic             sram_clock,
    input  logic             reset,
    sram_rr_arbiter_if.slave bus
);
    localparam int N   = NW + NR;
    localparam int PW  = $clog2(N);
    localparam int RW  = (NR > 1) ? $clog2(NR) : 1;
    localparam int TW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int TCW = $clog2(TAG_DEPTH + 1);
    localparam int BW  = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
    localparam int CW  = $clog2(RBUF_DEPTH + 1);
    localparam int WW  = MW + AW + DW;

    logic [PW-1:0]  ptr;
    logic           cmd_valid;
    logic           cmd_rd;
    logic [RW-1:0]  cmd_port;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_data;
    logic [MW-1:0]  cmd_mask;
    logic           perr;

    logic [RW-1:0]  tag_mem [TAG_DEPTH];
    logic [TW-1:0]  tag_wp;
    logic [TW-1:0]  tag_rp;
    logic [TCW-1:0] tag_cnt;

    logic           xfer;
    logic           can_grant;
    logic           tag_push;
    logic           tag_pop;
    logic           rd_pend;
    logic           tag_room;
    logic [RW-1:0]  tag_head;
    logic [NR-1:0]  room;
    logic [N-1:0]   elig;
    logic           found;
    logic           gnt;
    logic [PW-1:0]  gnt_idx;
    logic           gnt_rd;
    logic [WW-1:0]  gnt_w;
    logic [AW-1:0]  gnt_raddr;
    logic [RW-1:0]  gnt_port;

    assign xfer      = cmd_valid && bus.sram_ready;
    assign can_grant = !reset && (!cmd_valid || bus.sram_ready);
    assign tag_push  = xfer && cmd_rd;
    assign tag_pop   = bus.sram_data_out_valid && (tag_cnt != '0);
    assign tag_head  = tag_mem[tag_rp];
    // A read already sitting in the command register holds a reservation.
    assign rd_pend   = cmd_valid && cmd_rd;
    assign tag_room  = int'(tag_cnt) + int'(rd_pend) < TAG_DEPTH;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NW; i++)
            elig[i] = bus.w_valid[i];
        for (int j = 0; j < NR; j++)
            elig[NW+j] = bus.r_addr_valid[j] && tag_room && room[j];
    end

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && elig[i] && PW'(i) >= ptr) begin
                found   = 1'b1;
                gnt_idx = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && elig[i]) begin
                found   = 1'b1;
                gnt_idx = PW'(i);
            end
        end
    end

    assign gnt    = can_grant && found;
    assign gnt_rd = gnt_idx >= PW'(NW);

    always_comb begin
        bus.w_ready      = '0;
        bus.r_addr_ready = '0;
        gnt_w            = '0;
        gnt_raddr        = '0;
        gnt_port         = '0;
        for (int i = 0; i < NW; i++) begin
            if (gnt_idx == PW'(i)) begin
                gnt_w          = bus.w_din[i*WW +: WW];
                bus.w_ready[i] = gnt;
            end
        end
        for (int j = 0; j < NR; j++) begin
            if (gnt_idx == PW'(NW + j)) begin
                gnt_raddr           = bus.r_addr[j*AW +: AW];
                gnt_port            = RW'(j);
                bus.r_addr_ready[j] = gnt;
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            ptr       <= '0;
            cmd_valid <= 1'b0;
            cmd_rd    <= 1'b0;
            cmd_port  <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_mask  <= '0;
        end else begin
            if (xfer)
                cmd_valid <= 1'b0;
            if (gnt) begin
                ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                if (gnt_rd) begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= 1'b1;
                    cmd_port  <= gnt_port;
                    cmd_addr  <= gnt_raddr;
                    cmd_data  <= '0;
                    cmd_mask  <= '0;
                end else if (gnt_w[WW-1 -: MW] != '0) begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= 1'b0;
                    cmd_mask  <= gnt_w[WW-1 -: MW];
                    cmd_addr  <= gnt_w[DW +: AW];
                    cmd_data  <= gnt_w[DW-1:0];
                end
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
            perr    <= 1'b0;
        end else begin
            if (tag_push)
                tag_wp <= (tag_wp == TW'(TAG_DEPTH - 1)) ? '0 : tag_wp + 1'b1;
            if (tag_pop)
                tag_rp <= (tag_rp == TW'(TAG_DEPTH - 1)) ? '0 : tag_rp + 1'b1;
            tag_cnt <= tag_cnt + TCW'(tag_push) - TCW'(tag_pop);
            if (bus.sram_data_out_valid && tag_cnt == '0)
                perr <= 1'b1;
        end
    end

    always_ff @(posedge sram_clock) begin
        if (tag_push)
            tag_mem[tag_wp] <= cmd_port;
    end

    for (genvar g = 0; g < NR; g++) begin : g_port
        logic [CW-1:0] outst;
        logic [CW-1:0] cnt;
        logic [BW-1:0] wp;
        logic [BW-1:0] rp;
        logic [DW-1:0] mem [RBUF_DEPTH];
        logic          inc;
        logic          ret;
        logic          pop;
        logic          pend;

        assign inc  = tag_push && cmd_port == RW'(g);
        assign ret  = tag_pop && tag_head == RW'(g);
        assign pop  = (cnt != '0) && bus.r_data_ready[g];
        assign pend = rd_pend && cmd_port == RW'(g);
        assign room[g] =
            int'(outst) + int'(cnt) + int'(pend) < RBUF_DEPTH;

        assign bus.r_data_valid[g]     = cnt != '0;
        assign bus.r_data[g*DW +: DW] = (cnt != '0) ? mem[rp] : '0;

        always_ff @(posedge sram_clock) begin
            if (reset) begin
                outst <= '0;
                cnt   <= '0;
                wp    <= '0;
                rp    <= '0;
            end else begin
                outst <= outst + CW'(inc) - CW'(ret);
                cnt   <= cnt + CW'(ret) - CW'(pop);
                if (ret)
                    wp <= (wp == BW'(RBUF_DEPTH - 1)) ? '0 : wp + 1'b1;
                if (pop)
                    rp <= (rp == BW'(RBUF_DEPTH - 1)) ? '0 : rp + 1'b1;
            end
        end

        always_ff @(posedge sram_clock) begin
            if (ret)
                mem[wp] <= bus.sram_data_out;
        end
    end

    assign bus.sram_addr_valid = cmd_valid;
    assign bus.sram_addr       = cmd_addr;
    assign bus.sram_data_in    = cmd_data;
    assign bus.sram_write_mask = cmd_mask;
    assign bus.protocol_err    = perr;
endmodule
